// File: rtl/serial_capture_reg_if.sv
// Handshake bundle for serial_capture_reg: serial input side plus the parallel word/valid/ack side.
interface serial_capture_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             din;
    logic             ack;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             busy;
    logic             overrun;

    // Producer/consumer side: drives the serial stream and acknowledges words
    modport master (
        output start,
        output din,
        output ack,
        input  data,
        input  valid,
        input  busy,
        input  overrun
    );

    // Capture block side
    modport slave (
        input  start,
        input  din,
        input  ack,
        output data,
        output valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/serial_capture_reg.sv
// Serial-in/parallel-out capture stage: shifts WIDTH bits from the upstream DFF into a word
// and presents it with valid/ack, flagging a sticky overrun if a frame is requested too early.
module serial_capture_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               R,
    serial_capture_reg_if.slave bus
);
    localparam int unsigned    CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shift_in;

    // Old shift contents fall off the far end after WIDTH shifts, so no clear is needed at frame start
    assign shift_in = MSB_FIRST ? {shift_q[WIDTH-2:0], bus.din}
                                : {bus.din, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d = shift_in;
                    cnt_d   = CNT_W'(1);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shift_in;
                if (cnt_q == LAST_BIT) begin
                    data_d  = shift_in;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    valid_d = 1'b0;
                    // ack+start together chains straight into the next frame with no bubble
                    if (bus.start) begin
                        shift_d = shift_in;
                        cnt_d   = CNT_W'(1);
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.start) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.data    = data_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_serial_capture_reg.sv
// Scoreboard bench for serial_capture_reg: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_serial_capture_reg;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic R;
    logic start;
    logic din;
    logic ack;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q_msb[$];
    logic [W-1:0] q_lsb[$];
    int           busy_cycles;
    bit           valid_early;

    serial_capture_reg_if #(.WIDTH(W)) m_if ();
    serial_capture_reg_if #(.WIDTH(W)) l_if ();

    assign m_if.start = start;
    assign m_if.din   = din;
    assign m_if.ack   = ack;
    assign l_if.start = start;
    assign l_if.din   = din;
    assign l_if.ack   = ack;

    serial_capture_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .R(R), .bus(m_if));
    serial_capture_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .R(R), .bus(l_if));

    always #5 clk = ~clk;

    // First transmitted bit is bits[W-1]; LSB-first places it in data[0]
    function automatic logic [W-1:0] reverse_bits(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // Drives one frame (bits[W-1] first), records expectations and observes busy/valid during the shift.
    task automatic drive_frame(input logic [W-1:0] bits, input bit with_ack, input int glitch_at);
        busy_cycles = 0;
        valid_early = 1'b0;
        q_msb.push_back(bits);
        q_lsb.push_back(reverse_bits(bits));
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (m_if.busy === 1'b1 && l_if.busy === 1'b1) busy_cycles++;
                if (m_if.valid !== 1'b0 || l_if.valid !== 1'b0) valid_early = 1'b1;
            end
            start = (i == 0) || (i == glitch_at);
            ack   = with_ack && (i == 0);
            din   = bits[W-1-i];
        end
        @(negedge clk);
        start = 1'b0;
        ack   = 1'b0;
        din   = 1'b0;
    endtask

    task automatic test_reset();
        R = 1'b1; start = 1'b0; din = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (m_if.data !== '0 || m_if.valid !== 1'b0 || m_if.busy !== 1'b0 || m_if.overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold got data=%h valid=%b busy=%b ovr=%b want 00/0/0/0",
                     m_if.data, m_if.valid, m_if.busy, m_if.overrun);
        end
        R = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (m_if.valid !== 1'b0 || m_if.busy !== 1'b0 || l_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got valid=%b busy=%b want 0/0", m_if.valid, m_if.busy);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] em, el;
        drive_frame(8'hB2, 1'b0, -1);
        em = q_msb.pop_front();
        el = q_lsb.pop_front();
        total++;
        if (busy_cycles != 7 || valid_early) begin
            bad++;
            $display("FAIL basic_latency got busy_cycles=%0d valid_early=%0d want 7/0", busy_cycles, valid_early);
        end
        total++;
        if (m_if.valid !== 1'b1 || m_if.data !== em || m_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_msb got valid=%b data=%h busy=%b want 1/%h/0", m_if.valid, m_if.data, m_if.busy, em);
        end
        total++;
        if (l_if.valid !== 1'b1 || l_if.data !== el || l_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_lsb got valid=%b data=%h busy=%b want 1/%h/0", l_if.valid, l_if.data, l_if.busy, el);
        end
        repeat (3) @(negedge clk);
        total++;
        if (m_if.valid !== 1'b1 || m_if.data !== em || l_if.data !== el) begin
            bad++;
            $display("FAIL basic_hold got valid=%b data=%h/%h want 1/%h/%h", m_if.valid, m_if.data, l_if.data, em, el);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        total++;
        if (m_if.valid !== 1'b0 || l_if.valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_ack got valid=%b/%b want 0/0", m_if.valid, l_if.valid);
        end
    endtask

    task automatic test_ack_idle();
        logic [W-1:0] prev;
        prev = m_if.data;
        repeat (2) begin
            @(negedge clk); ack = 1'b1; din = 1'b1;
        end
        @(negedge clk); ack = 1'b0; din = 1'b0;
        @(negedge clk);
        total++;
        if (m_if.valid !== 1'b0 || m_if.busy !== 1'b0 || m_if.data !== prev || m_if.overrun !== 1'b0) begin
            bad++;
            $display("FAIL ack_idle got valid=%b busy=%b data=%h ovr=%b want 0/0/%h/0",
                     m_if.valid, m_if.busy, m_if.data, m_if.overrun, prev);
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] em, el;
        drive_frame(8'h96, 1'b0, 3);
        em = q_msb.pop_front();
        el = q_lsb.pop_front();
        total++;
        if (busy_cycles != 7 || valid_early) begin
            bad++;
            $display("FAIL ignored_start_len got busy_cycles=%0d valid_early=%0d want 7/0", busy_cycles, valid_early);
        end
        total++;
        if (m_if.valid !== 1'b1 || m_if.data !== em || l_if.data !== el || m_if.overrun !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start_data got valid=%b data=%h/%h ovr=%b want 1/%h/%h/0",
                     m_if.valid, m_if.data, l_if.data, m_if.overrun, em, el);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] em, el;
        drive_frame(8'hF0, 1'b1, -1);
        em = q_msb.pop_front();
        el = q_lsb.pop_front();
        total++;
        if (busy_cycles != 7 || valid_early) begin
            bad++;
            $display("FAIL b2b_bubble got busy_cycles=%0d valid_early=%0d want 7/0", busy_cycles, valid_early);
        end
        total++;
        if (m_if.valid !== 1'b1 || m_if.data !== em || l_if.data !== el) begin
            bad++;
            $display("FAIL b2b_data got valid=%b data=%h/%h want 1/%h/%h", m_if.valid, m_if.data, l_if.data, em, el);
        end
        total++;
        if (m_if.overrun !== 1'b0 || l_if.overrun !== 1'b0) begin
            bad++;
            $display("FAIL b2b_overrun got %b/%b want 0/0", m_if.overrun, l_if.overrun);
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] held, em, el;
        held = m_if.data;
        start = 1'b1; din = 1'b1;
        @(negedge clk);
        start = 1'b0; din = 1'b0;
        total++;
        if (m_if.overrun !== 1'b1 || m_if.valid !== 1'b1 || m_if.data !== held || m_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL overrun_set got ovr=%b valid=%b data=%h busy=%b want 1/1/%h/0",
                     m_if.overrun, m_if.valid, m_if.data, m_if.busy, held);
        end
        repeat (4) @(negedge clk);
        total++;
        if (m_if.overrun !== 1'b1 || l_if.overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky got %b/%b want 1/1", m_if.overrun, l_if.overrun);
        end
        drive_frame(8'hC6, 1'b1, -1);
        em = q_msb.pop_front();
        el = q_lsb.pop_front();
        total++;
        if (m_if.valid !== 1'b1 || m_if.data !== em || l_if.data !== el || m_if.overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_recapture got valid=%b data=%h/%h ovr=%b want 1/%h/%h/1",
                     m_if.valid, m_if.data, l_if.data, m_if.overrun, em, el);
        end
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] em, el;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 0); din = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        #2 R = 1'b1;
        #1;
        total++;
        if (m_if.data !== '0 || m_if.valid !== 1'b0 || m_if.busy !== 1'b0 || m_if.overrun !== 1'b0 ||
            l_if.data !== '0 || l_if.overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got data=%h valid=%b busy=%b ovr=%b want 00/0/0/0",
                     m_if.data, m_if.valid, m_if.busy, m_if.overrun);
        end
        repeat (2) @(negedge clk);
        R = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = i[0];
            @(negedge clk);
        end
        total++;
        if (m_if.valid !== 1'b0 || m_if.busy !== 1'b0 || l_if.valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_discard got valid=%b busy=%b want 0/0", m_if.valid, m_if.busy);
        end
        drive_frame(8'h81, 1'b0, -1);
        em = q_msb.pop_front();
        el = q_lsb.pop_front();
        total++;
        if (m_if.valid !== 1'b1 || m_if.data !== em || l_if.data !== el || m_if.overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_recover got valid=%b data=%h/%h ovr=%b want 1/%h/%h/0",
                     m_if.valid, m_if.data, l_if.data, m_if.overrun, em, el);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_idle();
        test_ignored_start();
        test_back_to_back();
        test_overrun();
        test_reset_midframe();
        total++;
        if (q_msb.size() != 0 || q_lsb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", q_msb.size(), q_lsb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_capture_reg.md
Name: serial_capture_reg

Overview:
- Serial-in, parallel-out capture stage; sits directly downstream of the gate-level DFF and consumes its registered Q stream one bit per clock.
- Assembles WIDTH bits into a parallel word under an FSM and presents the word with a valid/ack handshake.
- Flags overrun when a new frame is requested before the previous word is acknowledged.

Parameters:
- WIDTH, 8, number of bits per frame; legal range 2..16.
- MSB_FIRST, 1, 1 = first received bit lands in data[WIDTH-1]; 0 = first bit lands in data[0].

Ports:
- clk  input  1  rising-edge clock.
- R  input  1  asynchronous active-high reset; clears all state immediately.
- start  input  1  one-cycle request to begin a frame; din is sampled in the same cycle as bit 0.
- din  input  1  serial data bit (Q from the upstream DFF).
- ack  input  1  consumer acknowledge of the current word.
- data  output  WIDTH  captured word; stable while valid=1.
- valid  output  1  word available; held until acknowledged.
- busy  output  1  high while a frame is being shifted in.
- overrun  output  1  sticky error flag; cleared only by R.

Behaviour:
- Reset (R=1, asynchronous): state=IDLE, data=0, valid=0, busy=0, overrun=0, bit counter=0. These outputs hold for as long as R stays high. R asserted mid-frame discards the partial word without raising valid.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 -> sample din as bit 0; go to SHIFT; busy=1; counter=1.
  - start=0 -> stay in IDLE.
- SHIFT:
  - Sample din on each rising edge and increment the counter. start is ignored here.
  - On the edge that samples bit WIDTH-1:
    - Load the assembled word into data.
    - Set valid=1 and busy=0.
    - Go to HOLD.
  - Latency: valid rises on the edge WIDTH-1 cycles after the edge that sampled start.
- Bit placement:
  - MSB_FIRST=1: shift left and insert din at the LSB; the first bit ends up in data[WIDTH-1].
  - MSB_FIRST=0: shift right and insert din at the MSB; the first bit ends up in data[0].
  - The internal shift register is separate from data, so data never shows partial words.
- HOLD:
  - valid=1 and data stays frozen.
  - ack=1 -> valid=0 on the next edge; go to IDLE.
  - ack=1 and start=1 in the same cycle -> clear valid, sample din as bit 0, go directly to SHIFT. No bubble.
  - start=1 with ack=0 -> set overrun=1, ignore start, and keep data and valid unchanged.
- ack while valid=0 has no effect.
- Counter width is clog2(WIDTH)+1. It wraps to 0 at frame end and never overflows.
- din is used only when start is accepted or the FSM is in SHIFT; it is don't-care otherwise.

Test Plan:
- Reset: drive R=1 mid-frame after 3 of 8 bits -> data=0x00, valid=0, busy=0, overrun=0 immediately. After releasing R, the FSM is in IDLE and busy=0.
- Basic MSB-first capture (WIDTH=8): start with din sequence 1,0,1,1,0,0,1,0 -> busy high for 7 cycles; valid rises 7 edges after start; data=0xB2. valid holds until ack, then falls on the next edge.
- LSB-first capture (MSB_FIRST=0): same din sequence -> data=0x4D.
- Back-to-back frames: ack and start in the same cycle as the first bit of frame 2 (din 1,1,1,1,0,0,0,0) -> frame 2 data=0xF0. No bubble cycle and no overrun.
- Overrun: pulse start while valid=1 and ack=0 -> overrun=1 and stays 1. data keeps the previous word. A later ack plus start captures normally with overrun still 1 until R.
- Ignored start: pulse start during SHIFT -> the frame completes unchanged and the bit count is unaffected. ack with valid=0 causes no state change.
